// File: rtl/seg_scan_if.sv
// -----------------------------------------------------------------------------
// seg_scan_if
// Glyph update port of the 7-segment scan controller.
//
// Handshake: upd_valid is a single-cycle strobe with no ready. The controller
// always accepts; upd_data is captured on every clock edge where upd_valid=1.
// upd_pending reports that a captured update has not yet reached the active
// (displayed) buffer. It clears on the next frame boundary.
//
// Signals
//   upd_valid    master -> slave  1-cycle capture strobe
//   upd_data     master -> slave  DIGITS*8 glyphs, digit i = [8i+7:8i],
//                                 active-low {dp,g,f,e,d,c,b,a}, 8'hFF = blank
//   upd_pending  slave -> master  captured update not yet applied
// -----------------------------------------------------------------------------
interface seg_scan_if #(
  parameter int DIGITS = 8
);
  logic                  upd_valid;
  logic [DIGITS*8-1:0]   upd_data;
  logic                  upd_pending;

  modport master (output upd_valid, output upd_data, input upd_pending);
  modport slave  (input upd_valid, input upd_data, output upd_pending);
endinterface

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Multiplexed 7-segment scan controller with double-buffered glyphs, per-digit
// blink, PWM brightness, an all-anodes-off guard at the start of each digit
// slot and configurable segment/anode polarity.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   upd          slave modport of seg_scan_if (upd_valid, upd_data, upd_pending)
//   blink_mask   in   DIGITS, 1 = digit blinks
//   brightness   in   BRIGHT_W, 0 = dimmest, all-ones = full duty
//   seg_out      out  8, segment drive (registered)
//   seg_an       out  DIGITS, one-hot digit enable (registered)
//   frame_tick   out  1-cycle pulse on the frame-boundary cycle
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 65536,
  parameter int BRIGHT_W       = 3,
  parameter int GUARD          = 4,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_scan_if.slave           upd,
  input  logic [DIGITS-1:0]   blink_mask,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic [7:0]          seg_out,
  output logic [DIGITS-1:0]   seg_an,
  output logic                frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0]     CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [FW-1:0]     FRM_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [7:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CW-1:0]          scan_cnt;
  logic [IW-1:0]          scan_idx;
  logic [FW-1:0]          blink_cnt;
  logic                   blink_phase;
  logic [DIGITS-1:0][7:0] active_q;
  logic [DIGITS-1:0][7:0] pending_q;
  logic                   pending_flag;

  logic                   boundary;
  logic                   guard_ok;
  logic [BRIGHT_W-1:0]    dim_phase;
  logic                   an_en;
  logic [7:0]             glyph;
  logic [DIGITS-1:0]      onehot;
  logic [7:0]             seg_nx;
  logic [DIGITS-1:0]      an_nx;

  // Last cycle of the last digit slot: the frame boundary.
  assign boundary   = (scan_cnt == CNT_LAST) && (scan_idx == IDX_LAST);
  assign frame_tick = boundary;
  assign upd.upd_pending = pending_flag;

  // Top BRIGHT_W bits of the slot counter select the PWM phase.
  assign dim_phase = scan_cnt[CW-1 -: BRIGHT_W];

  // A zero guard would make the comparison trivially true, so it is elided.
  if (GUARD == 0) begin : g_no_guard
    assign guard_ok = 1'b1;
  end else begin : g_guard
    assign guard_ok = (scan_cnt >= CW'(GUARD));
  end

  // Scan position and blink timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt    <= '0;
      scan_idx    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
      if (scan_cnt == CNT_LAST) begin
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
      end
      if (boundary) begin
        if (blink_cnt == FRM_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + FW'(1);
        end
      end
    end
  end

  // Glyph double buffer. The active buffer only changes on the boundary cycle,
  // so a frame is always drawn from one consistent glyph set. A strobe on the
  // boundary itself bypasses the pending buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q     <= '1;
      pending_q    <= '1;
      pending_flag <= 1'b0;
    end else if (boundary) begin
      if (upd.upd_valid) begin
        active_q     <= upd.upd_data;
        pending_flag <= 1'b0;
      end else if (pending_flag) begin
        active_q     <= pending_q;
        pending_flag <= 1'b0;
      end
    end else if (upd.upd_valid) begin
      pending_q    <= upd.upd_data;
      pending_flag <= 1'b1;
    end
  end

  // Next output values from the current scan position.
  always_comb begin
    glyph  = active_q[scan_idx];
    onehot = DIGITS'(1) << scan_idx;
    seg_nx = SEG_OFF;
    an_nx  = AN_OFF;
    // Blinked digits keep their anode so the duty cycle is unchanged.
    if (blink_phase && blink_mask[scan_idx]) begin
      glyph = 8'hFF;
    end
    an_en = guard_ok && (dim_phase <= brightness);
    if (an_en) begin
      seg_nx = (SEG_ACTIVE_LOW != 0) ? glyph : ~glyph;
      an_nx  = (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= SEG_OFF;
      seg_an  <= AN_OFF;
    end else begin
      seg_out <= seg_nx;
      seg_an  <= an_nx;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Directed bench for seg_scan_ctrl with DIGITS=4, SCAN_DIV=16, BRIGHT_W=2,
// GUARD=0, BLINK_FRAMES=2, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=1.
// Expected outputs are derived from absolute cycle count since reset release:
// a 16-cycle slot, 4 slots per 64-cycle frame, blink phase = (frame/2)%2.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int DIGITS       = 4;
  localparam int SLOT         = 16;
  localparam int FRAME        = SLOT * DIGITS;
  localparam int BLINK_FRAMES = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DIGITS-1:0] blink_mask;
  logic [1:0]        brightness;
  logic [7:0]        seg_out;
  logic [DIGITS-1:0] seg_an;
  logic              frame_tick;

  seg_scan_if #(.DIGITS(DIGITS)) upd_if ();

  seg_scan_ctrl #(
    .DIGITS(DIGITS), .SCAN_DIV(SLOT), .BRIGHT_W(2), .GUARD(0),
    .BLINK_FRAMES(BLINK_FRAMES), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd        (upd_if),
    .blink_mask (blink_mask),
    .brightness (brightness),
    .seg_out    (seg_out),
    .seg_an     (seg_an),
    .frame_tick (frame_tick)
  );

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  int          cyc;
  logic [31:0] m_active;
  logic [31:0] m_pend_data;
  bit          m_pend;
  logic [11:0] exp_q[$];  // {seg_an, seg_out}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  // Outputs visible in cycle c+1 are produced from the scan position of cycle c.
  function automatic logic [11:0] exp_out(input int c);
    int         cnt;
    int         idx;
    int         ph;
    bit         blank;
    logic [7:0] g;
    cnt   = c % SLOT;
    idx   = (c / SLOT) % DIGITS;
    ph    = cnt / 4;
    blank = ((((c / FRAME) / BLINK_FRAMES) % 2) == 1) && blink_mask[idx];
    g     = m_active[idx*8 +: 8];
    if (blank) g = 8'hFF;
    if (ph <= int'(brightness)) return {~(4'b0001 << idx), ~g};
    return {4'hF, 8'h00};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [11:0] e;
    exp_q.push_back(exp_out(cyc));
    if (cyc % FRAME == FRAME - 1) begin
      if (upd_if.upd_valid) begin
        m_active = upd_if.upd_data;
        m_pend   = 1'b0;
      end else if (m_pend) begin
        m_active = m_pend_data;
        m_pend   = 1'b0;
      end
    end else if (upd_if.upd_valid) begin
      m_pend_data = upd_if.upd_data;
      m_pend      = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e = exp_q.pop_front();
    chk("seg_an", 32'(seg_an), 32'(e[11:8]));
    chk("seg_out", 32'(seg_out), 32'(e[7:0]));
    chk("frame_tick", 32'(frame_tick), 32'(cyc % FRAME == FRAME - 1));
    chk("upd_pending", 32'(upd_if.upd_pending), 32'(m_pend));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input logic [31:0] data);
    upd_if.upd_valid = 1'b1;
    upd_if.upd_data  = data;
    tick();
    upd_if.upd_valid = 1'b0;
  endtask

  task automatic model_reset();
    cyc         = 0;
    m_active    = '1;
    m_pend_data = '1;
    m_pend      = 1'b0;
    exp_q.delete();
  endtask

  // Global time limit so a stuck clock can never hang the run.
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "time limit reached");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit found;
    upd_if.upd_valid = 1'b0;
    upd_if.upd_data  = '0;
    blink_mask       = 4'b0010;
    brightness       = 2'd3;
    model_reset();

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_seg_an", 32'(seg_an), 32'h0000_000F);
    chk("rst_seg_out", 32'(seg_out), 32'h0000_0000);
    chk("rst_pending", 32'(upd_if.upd_pending), 32'h0);
    chk("rst_frame_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;

    // Frame 0 blank; update at cycle 5 lands in frame 1.
    run(5);
    strobe(32'hF9A4_B099);
    run(60);
    chk("f1_d0_an", 32'(seg_an), 32'h0000_000E);
    chk("f1_d0_seg", 32'(seg_out), 32'h0000_0066);
    run(16);
    chk("f1_d1_an", 32'(seg_an), 32'h0000_000D);
    chk("f1_d1_seg", 32'(seg_out), 32'h0000_004F);
    run(2);

    // Mid-frame update at frame cycle 20: shows from frame 2.
    strobe(32'hC0C0_C0C0);
    run(53);

    // Two strobes in frame 2: the last one wins in frame 3.
    strobe(32'h1122_3344);
    run(5);
    strobe(32'h5566_7788);
    run(47);

    // Half brightness; find the boundary from the DUT's frame_tick.
    brightness = 2'd1;
    found = 1'b0;
    for (int i = 0; i < FRAME + 2 && !found; i++) begin
      if (frame_tick) found = 1'b1;
      else tick();
    end
    chk("frame_tick_seen", 32'(found), 32'h1);

    // Strobe on the boundary cycle: no pending phase, applied to frame 4.
    strobe(32'hA1B2_C3D4);
    brightness = 2'd3;
    run(128);
    brightness = 2'd2;
    run(128);

    // Mid-frame reset with an update still pending.
    run(10);
    strobe(32'hDEAD_BEEF);
    run(19);
    rst_n = 1'b0;
    #1;
    chk("async_rst_seg_an", 32'(seg_an), 32'h0000_000F);
    chk("async_rst_seg_out", 32'(seg_out), 32'h0000_0000);
    chk("async_rst_pending", 32'(upd_if.upd_pending), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    brightness = 2'd3;
    rst_n = 1'b1;
    run(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
